pc_stack_unit: RTL
==================

Name: pc_stack_unit

Overview:
Parametrised program-counter unit for the CPU fetch stage. It adds PC-relative branches, an internal hardware return-address stack for call/ret, interrupt entry, and stall support. It drives the instruction-memory address and takes control strobes from the decoder. The ret path no longer needs an external stack operand.

Parameters:
AW, 16, PC/address width in bits.
RESET_VEC, 1024, PC value after reset.
IRQ_VEC, 8, PC loaded on interrupt entry.
DEPTH, 8, return-stack entries (power of 2, >=2).
OFFW, 8, branch offset width (two's complement).

Ports:
CLK  in  1  clock; all state updates on falling edge.
RST  in  1  reset, asynchronous, active-high.
stall  in  1  hold all state this edge.
inc  in  1  PC <= PC+1.
jmp  in  1  PC <= jmp_addr.
jmp_addr  in  AW  absolute jump target.
br  in  1  PC <= PC + sext(br_off).
br_off  in  OFFW  signed branch offset.
call  in  1  push PC+1, PC <= jmp_addr.
ret  in  1  pop, PC <= popped value.
irq  in  1  push PC, PC <= IRQ_VEC.
clr_err  in  1  clear sticky error flags.
pc  out  AW  current program counter.
sp  out  clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
stk_full  out  1  sp==DEPTH.
stk_empty  out  1  sp==0.
ovf  out  1  sticky; push attempted when full.
unf  out  1  sticky; pop attempted when empty.

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_VEC, sp=0, ovf=0, unf=0, stk_empty=1, stk_full=0. Stack RAM contents are don't-care.
- At each falling edge, the first active input in this priority order is acted on: stall > irq > ret > call > jmp > br > inc. Lower-priority strobes asserted at the same edge are ignored, with no side effects.
- If none is active, pc holds.
- stall: pc, sp and stack hold. clr_err is still honoured.
- inc: pc <= pc+1, modulo 2^AW (0xFFFF -> 0x0000 for AW=16).
- jmp: pc <= jmp_addr.
- br: pc <= pc + sign-extended br_off, modulo 2^AW.
- call when not full: stack[sp] <= pc+1 (mod 2^AW), sp <= sp+1, pc <= jmp_addr.
- call when full: pc <= jmp_addr, stack and sp unchanged, ovf <= 1.
- irq: same push rules as call, but the pushed value is the unincremented pc (resume address) and pc <= IRQ_VEC. If the stack is full, ovf <= 1 and the vector is still taken.
- ret when not empty: pc <= stack[sp-1], sp <= sp-1.
- ret when empty: pc, sp unchanged; unf <= 1.
- Updates take effect in the same cycle: pc and sp are valid after the edge, with zero additional latency. The stack read is combinational from stack[sp-1].
- clr_err clears ovf/unf at the edge. If a new error occurs at the same edge, set wins.
- Flag decode is combinational from sp: stk_full = (sp==DEPTH), stk_empty = (sp==0).
- ovf/unf remain set until clr_err or RST.

Test Plan:
- Reset/inc: RST pulse -> pc=1024, sp=0, empty=1; 3 edges with inc -> pc=1027; inc with stall=1 -> pc stays 1027.
- Wrap/branch: jmp 0xFFFF, inc -> pc=0x0000; at pc=0x0010, br_off=8'hF0 -> pc=0x0000; br_off=8'h05 at 0x0010 -> 0x0015.
- Call/ret nesting: at pc=1030, call to 0x2000 -> sp=1, pc=0x2000; call to 0x3000 -> sp=2; ret -> pc=0x2001, sp=1; ret -> pc=1031, sp=0.
- Overflow/underflow: DEPTH=8, 9 calls -> sp=8, full=1, ovf=1, pc=last target; 8 rets restore in LIFO order; 9th ret -> pc unchanged, unf=1; clr_err -> ovf=unf=0.
- Priority/irq: irq+ret+inc at the same edge with pc=0x0100 -> pc=8, top of stack=0x0100, sp+1; subsequent ret -> pc=0x0100.
- Async reset mid-stack: sp=3 at pc=0x2000, RST asserted between edges -> pc=1024 and sp=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Decoder-side control strobes and program-counter status of the fetch-stage PC unit.
// Strobes are level-qualified per falling clock edge; there is no valid/ready backpressure.
interface pc_stack_unit_if #(
  parameter int AW    = 16,
  parameter int OFFW  = 8,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic            stall;
  logic            inc;
  logic            jmp;
  logic [AW-1:0]   jmp_addr;
  logic            br;
  logic [OFFW-1:0] br_off;
  logic            call;
  logic            ret;
  logic            irq;
  logic            clr_err;
  logic [AW-1:0]   pc;
  logic [SPW-1:0]  sp;
  logic            stk_full;
  logic            stk_empty;
  logic            ovf;
  logic            unf;

  modport master (
    output stall, inc, jmp, jmp_addr, br, br_off, call, ret, irq, clr_err,
    input  pc, sp, stk_full, stk_empty, ovf, unf
  );

  modport slave (
    input  stall, inc, jmp, jmp_addr, br, br_off, call, ret, irq, clr_err,
    output pc, sp, stk_full, stk_empty, ovf, unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative branches, an internal return-address stack,
// interrupt entry and stall. All state changes on the falling edge of CLK.
module pc_stack_unit #(
  parameter int AW        = 16,
  parameter int RESET_VEC = 1024,
  parameter int IRQ_VEC   = 8,
  parameter int DEPTH     = 8,
  parameter int OFFW      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  pc_stack_unit_if.slave    bus
);
  localparam int SPW  = $clog2(DEPTH) + 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [AW-1:0]  RST_PC  = AW'(RESET_VEC);
  localparam logic [AW-1:0]  IRQ_PC  = AW'(IRQ_VEC);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]   pc_q, pc_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [AW-1:0]   stack_q [DEPTH];

  logic            full, empty;
  logic            push;
  logic [AW-1:0]   push_val;
  logic            ovf_set, unf_set;
  logic [PTRW-1:0] top_idx;
  logic [AW-1:0]   br_ext;

  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[PTRW-1:0] - PTRW'(1);
  assign br_ext  = {{(AW-OFFW){bus.br_off[OFFW-1]}}, bus.br_off};

  // Strict priority: only the highest active strobe has any effect this edge.
  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    push     = 1'b0;
    push_val = '0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.irq) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        push     = 1'b1;
        push_val = pc_q;
        sp_d     = sp_q + SPW'(1);
      end
      pc_d = IRQ_PC;
    end else if (bus.ret) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        pc_d = stack_q[top_idx];
        sp_d = sp_q - SPW'(1);
      end
    end else if (bus.call) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        push     = 1'b1;
        push_val = pc_q + AW'(1);
        sp_d     = sp_q + SPW'(1);
      end
      pc_d = bus.jmp_addr;
    end else if (bus.jmp) begin
      pc_d = bus.jmp_addr;
    end else if (bus.br) begin
      pc_d = pc_q + br_ext;
    end else if (bus.inc) begin
      pc_d = pc_q + AW'(1);
    end
    // A new error at the same edge as clr_err wins.
    ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    unf_d = unf_set | (unf_q & ~bus.clr_err);
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= RST_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage is not reset; sp alone defines which entries are live.
  always_ff @(negedge CLK) begin
    if (push) begin
      stack_q[sp_q[PTRW-1:0]] <= push_val;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.sp        = sp_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule
